decode_queue_stage: RTL and testbench
=====================================

// Module: decode_queue_stage
// PURPOSE
//  Parametrised decode stage with DEPTH-entry instruction queue between fetch and decode.
//  Decodes the queue head into a registered output slot, holds it on RAW hazards via an
//  internal per-register reservation scoreboard, and kills all queued/decoded work on flush.
//  Sits between fetch (v_i/stall_o) and register read/execute (v_o/stall_i).
// PARAMETERS
//  DEPTH   4   queue entries, power of two, >=2
//  WORD    32  instruction width
//  ADDR    32  pc width
//  W_RD    5   register-index width; scoreboard has 2**W_RD bits
//  W_IMM   16  immediate field width (inst[W_IMM-1:0])
//  W_BRID  3   branch-id tag width
//  D_INFO  16  decoded-info width (bit indices WRSV, USE_R0, USE_R1 from params package)
// PORTS
//  clk        in   1       clock
//  reset      in   1       reset, asynchronous, active-low
//  v_i        in   1       fetch instruction valid
//  stall_o    out  1       queue full; fetch must hold inst_i/pc_i/brid_i
//  inst_i     in   WORD    instruction: [WORD-1:2W_RD+W_IMM] op, then r0, r1, imm
//  pc_i       in   ADDR    instruction pc
//  brid_i     in   W_BRID  branch-id tag
//  flush_i    in   1       branch mispredict: kill queue and output slot
//  v_o        out  1       output slot valid
//  stall_i    in   1       downstream not accepting
//  pc_o, brid_o, imm_o, d_info_o  out  ADDR/W_BRID/W_IMM/D_INFO  registered decoded fields
//  r0_o, r1_o out  W_RD    register indices; r0_o is also writeback target
//  wb_v_i     in   1       writeback completes, releases reservation
//  wb_r_i     in   W_RD    writeback register
//  busy_o     out  1       queue non-empty or output slot valid
// BEHAVIOUR
//  Reset: queue empty, rd/wr ptr 0, count 0, v_o=0, all outputs 0, scoreboard all 0.
//  Push: v_i & ~stall_o & ~flush_i writes entry {inst,pc,brid}; stall_o = (count==DEPTH),
//   registered, no same-cycle full bypass (push rejected at full even if popping).
//  Issue (handshake): v_o & ~stall_i. On issue, if d_info_o[WRSV], set sb[r0_o].
//  Pop: head valid & ~hazard & (~v_o | ~stall_i) & ~flush_i; head decoded via decode_inst,
//   loaded into output slot; v_o=1 next cycle. Else if issue without pop, v_o<=0.
//  Hazard: for each used source (USE_R0->r0, USE_R1->r1) of head:
//   sb[src]=1, or (v_o & d_info_o[WRSV] & r0_o==src). Checked vs registered sb only;
//   writeback clears visible next cycle (1-cycle release latency).
//  Latency: empty queue, push at edge t -> pop at edge t+1 -> v_o high after t+1 (2 cycles).
//  Throughput: 1 instr/cycle sustained with no hazards and stall_i=0.
//  Outputs hold stable while v_o & stall_i.
//  Simultaneous set/clear same register: set wins. wb of unreserved reg: no effect.
//  Flush: next cycle count=0, ptrs equal, v_o=0; input that cycle discarded; scoreboard
//   kept (issued instrs are older than the branch); flush beats push, pop and issue-set.
//  Pointers wrap modulo DEPTH; count W=$clog2(DEPTH)+1 bits, never exceeds DEPTH.
//  Async reset mid-operation: immediate return to reset state, no partial entries.
// STRUCTURE
//  Params package (extends params.v): WORD, ADDR, W_RD, W_IMM, W_BRID, D_INFO, bit indices
//   WRSV/USE_R0/USE_R1; decode_inst function stays in shared decode_inst.v.
//  Sub-module inst_queue (DEPTH x {WORD,ADDR,W_BRID}, push/pop/flush, count/full/empty).
//  Scoreboard and hazard logic inline in decode_queue_stage.
// TESTING
//  Stream 6 independent instrs, stall_i=0 -> v_o from cycle 2, 6 consecutive valid, pcs in order.
//  stall_i=1 for 8 cycles with v_i=1 -> stall_o high after DEPTH+1 accepts; v_o held, no loss.
//  I0 writes r3 (WRSV), I1 reads r3 -> I1 held; wb_v_i,wb_r_i=3 -> I1 v_o 2 cycles later.
//  Same-cycle issue setting r5 and wb of r5 -> sb[5]=1 after edge; reader of r5 held.
//  Queue holding 3 + valid slot, flush_i with v_i=1 -> v_o=0, busy_o=0 next cycle, input dropped.
//  Assert reset while full -> all outputs 0 and stall_o=0 immediately, before next clk edge.

Source files
------------

// File: rtl/decode_queue_stage_pkg.sv
// Shared widths, decoded-info bit positions and the instruction decoder
// used by the decode/queue stage.
package decode_queue_stage_pkg;

    localparam int WORD   = 32;
    localparam int ADDR   = 32;
    localparam int W_RD   = 5;
    localparam int W_IMM  = 16;
    localparam int W_BRID = 3;
    localparam int D_INFO = 16;

    // Opcode occupies whatever is left above r0, r1 and the immediate.
    localparam int W_OP = WORD - 2 * W_RD - W_IMM;

    // Decoded-info flag positions; the raw opcode is carried above them.
    localparam int WRSV        = 0;
    localparam int USE_R0      = 1;
    localparam int USE_R1      = 2;
    localparam int INFO_OP_LSB = 3;

    typedef struct packed {
        logic [D_INFO-1:0] d_info;
        logic [W_RD-1:0]   r0;
        logic [W_RD-1:0]   r1;
        logic [W_IMM-1:0]  imm;
    } decoded_t;

    // Layout: {op, r0, r1, imm}. The low three opcode bits directly select
    // write-reserve of r0, read of r0 and read of r1.
    function automatic decoded_t decode_inst(input logic [WORD-1:0] inst);
        decoded_t        d;
        logic [W_OP-1:0] op;
        op       = inst[WORD-1 -: W_OP];
        d.r0     = inst[W_IMM+2*W_RD-1 -: W_RD];
        d.r1     = inst[W_IMM+W_RD-1 -: W_RD];
        d.imm    = inst[W_IMM-1:0];
        d.d_info = '0;
        d.d_info[INFO_OP_LSB +: W_OP] = op;
        d.d_info[WRSV]   = op[0];
        d.d_info[USE_R0] = op[1];
        d.d_info[USE_R1] = op[2];
        return d;
    endfunction

endpackage

// File: rtl/decode_queue_stage_inst_queue.sv
// Circular instruction queue between fetch and decode. Push is ignored
// when full, pop when empty; flush empties it in one cycle.
module inst_queue
    import decode_queue_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W_ENT = WORD + ADDR + W_BRID
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W_ENT-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W_ENT-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W_ENT-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Entry storage: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers and occupancy; flush drops everything by catching rd up to wr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage: queues fetched instructions, decodes the head into a
// registered output slot, blocks RAW hazards with a per-register
// reservation scoreboard and discards all queued work on flush.
module decode_queue_stage
    import decode_queue_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              v_i,
    output logic              stall_o,
    input  logic [WORD-1:0]   inst_i,
    input  logic [ADDR-1:0]   pc_i,
    input  logic [W_BRID-1:0] brid_i,
    input  logic              flush_i,
    output logic              v_o,
    input  logic              stall_i,
    output logic [ADDR-1:0]   pc_o,
    output logic [W_BRID-1:0] brid_o,
    output logic [W_IMM-1:0]  imm_o,
    output logic [D_INFO-1:0] d_info_o,
    output logic [W_RD-1:0]   r0_o,
    output logic [W_RD-1:0]   r1_o,
    input  logic              wb_v_i,
    input  logic [W_RD-1:0]   wb_r_i,
    output logic              busy_o
);

    localparam int W_ENT = WORD + ADDR + W_BRID;
    localparam int NREG  = 2 ** W_RD;

    logic [W_ENT-1:0]        head;
    logic [$clog2(DEPTH):0]  q_count;
    logic                    q_full, q_empty;
    logic [WORD-1:0]         head_inst;
    logic [ADDR-1:0]         head_pc;
    logic [W_BRID-1:0]       head_brid;
    decoded_t                dec;
    logic                    hazard, push, pop, issue, sb_set;
    logic [NREG-1:0]         sb_q, sb_d;

    logic                    v_o_q, v_o_d;
    logic [ADDR-1:0]         pc_q, pc_d;
    logic [W_BRID-1:0]       brid_q, brid_d;
    logic [W_IMM-1:0]        imm_q, imm_d;
    logic [D_INFO-1:0]       d_info_q, d_info_d;
    logic [W_RD-1:0]         r0_q, r0_d, r1_q, r1_d;

    inst_queue #(.DEPTH(DEPTH), .W_ENT(W_ENT)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  ({inst_i, pc_i, brid_i}),
        .pop_i   (pop),
        .flush_i (flush_i),
        .head_o  (head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign {head_inst, head_pc, head_brid} = head;
    assign dec = decode_inst(head_inst);

    // Full is taken from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign stall_o = q_full;
    assign push    = v_i & ~q_full & ~flush_i;
    assign issue   = v_o_q & ~stall_i;
    assign pop     = ~q_empty & ~hazard & (~v_o_q | ~stall_i) & ~flush_i;
    assign sb_set  = issue & d_info_q[WRSV] & ~flush_i;
    assign busy_o  = (q_count != '0) | v_o_q;

    // A source is blocked if already reserved, or if the slot instruction
    // (not yet issued, so not yet in the scoreboard) will write it.
    always_comb begin
        hazard = 1'b0;
        if (dec.d_info[USE_R0] &&
            (sb_q[dec.r0] || (v_o_q && d_info_q[WRSV] && r0_q == dec.r0)))
            hazard = 1'b1;
        if (dec.d_info[USE_R1] &&
            (sb_q[dec.r1] || (v_o_q && d_info_q[WRSV] && r0_q == dec.r1)))
            hazard = 1'b1;
    end

    // Per-register reservation: issue sets, writeback clears, set wins.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            assign sb_d[gi] = (sb_set && r0_q == W_RD'(gi)) ||
                              (sb_q[gi] && !(wb_v_i && wb_r_i == W_RD'(gi)));
        end
    endgenerate

    // Scoreboard register; survives flush because issued work is older.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    // Output slot next state: flush kills, pop loads, lone issue empties.
    always_comb begin
        v_o_d    = v_o_q;
        pc_d     = pc_q;
        brid_d   = brid_q;
        imm_d    = imm_q;
        d_info_d = d_info_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        if (flush_i) begin
            v_o_d = 1'b0;
        end else if (pop) begin
            v_o_d    = 1'b1;
            pc_d     = head_pc;
            brid_d   = head_brid;
            imm_d    = dec.imm;
            d_info_d = dec.d_info;
            r0_d     = dec.r0;
            r1_d     = dec.r1;
        end else if (issue) begin
            v_o_d = 1'b0;
        end
    end

    // Output slot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_o_q    <= 1'b0;
            pc_q     <= '0;
            brid_q   <= '0;
            imm_q    <= '0;
            d_info_q <= '0;
            r0_q     <= '0;
            r1_q     <= '0;
        end else begin
            v_o_q    <= v_o_d;
            pc_q     <= pc_d;
            brid_q   <= brid_d;
            imm_q    <= imm_d;
            d_info_q <= d_info_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
        end
    end

    assign v_o      = v_o_q;
    assign pc_o     = pc_q;
    assign brid_o   = brid_q;
    assign imm_o    = imm_q;
    assign d_info_o = d_info_q;
    assign r0_o     = r0_q;
    assign r1_o     = r1_q;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Self-checking bench for decode_queue_stage: directed scenarios plus a
// randomized run checked against an in-order transaction model.
`timescale 1ns/1ps
module tb_decode_queue_stage;
    import decode_queue_stage_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              v_i = 1'b0, flush_i = 1'b0, stall_i = 1'b0, wb_v_i = 1'b0;
    logic [WORD-1:0]   inst_i = '0;
    logic [ADDR-1:0]   pc_i = '0;
    logic [W_BRID-1:0] brid_i = '0;
    logic [W_RD-1:0]   wb_r_i = '0;
    logic              stall_o, v_o, busy_o;
    logic [ADDR-1:0]   pc_o;
    logic [W_BRID-1:0] brid_o;
    logic [W_IMM-1:0]  imm_o;
    logic [D_INFO-1:0] d_info_o;
    logic [W_RD-1:0]   r0_o, r1_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [ADDR-1:0]   pc;
        logic [W_BRID-1:0] brid;
        logic [WORD-1:0]   inst;
    } ent_t;
    ent_t exp_q[$];
    bit   rsv[32];
    logic [ADDR-1:0] pc_ctr;

    decode_queue_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .v_i(v_i), .stall_o(stall_o), .inst_i(inst_i),
        .pc_i(pc_i), .brid_i(brid_i), .flush_i(flush_i), .v_o(v_o), .stall_i(stall_i),
        .pc_o(pc_o), .brid_o(brid_o), .imm_o(imm_o), .d_info_o(d_info_o),
        .r0_o(r0_o), .r1_o(r1_o), .wb_v_i(wb_v_i), .wb_r_i(wb_r_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WORD-1:0] mk_inst(input logic [5:0] op, input logic [W_RD-1:0] r0,
                                                input logic [W_RD-1:0] r1, input logic [W_IMM-1:0] imm);
        return {op, r0, r1, imm};
    endfunction

    // ISA rule: info = opcode shifted above three flags; flags = opcode bits 0..2.
    function automatic logic [D_INFO-1:0] exp_info(input logic [5:0] op);
        return (D_INFO'(op) << 3) | D_INFO'(op & 6'd7);
    endfunction

    task automatic set_idle();
        v_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; wb_v_i = 1'b0; wb_r_i = '0;
    endtask

    task automatic do_reset();
        set_idle();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic push_in(input logic [5:0] op, input logic [W_RD-1:0] r0, input logic [W_RD-1:0] r1,
                           input logic [ADDR-1:0] pc);
        v_i = 1'b1; inst_i = mk_inst(op, r0, r1, pc[15:0] ^ 16'h5a5a); pc_i = pc; brid_i = pc[4:2];
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({v_o, stall_o, busy_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got v/stall/busy=%b expected 000", {v_o, stall_o, busy_o});
        end
        n_tests++;
        if ({pc_o, brid_o, imm_o, d_info_o, r0_o, r1_o} !== '0) begin
            n_fail++; $display("FAIL reset_fields: got pc=%h info=%h expected zeros", pc_o, d_info_o);
        end
        reset = 1'b1;
    endtask

    task automatic test_stream();
        logic [ADDR-1:0] epc;
        logic [5:0]      op;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_tests++;
            if (v_o !== (c >= 2 && c <= 7)) begin
                n_fail++; $display("FAIL stream_v_o c=%0d: got %b expected %b", c, v_o, (c >= 2 && c <= 7));
            end
            n_tests++;
            if (stall_o !== 1'b0) begin n_fail++; $display("FAIL stream_stall c=%0d: got %b expected 0", c, stall_o); end
            if (c >= 2 && c <= 7) begin
                epc = 32'h100 + 32'(4 * (c - 2));
                op  = {3'(c - 2), 3'b001};
                n_tests++;
                if (pc_o !== epc || d_info_o !== exp_info(op) || r0_o !== W_RD'(c + 8)) begin
                    n_fail++; $display("FAIL stream_data c=%0d: got pc=%h info=%h r0=%0d expected pc=%h info=%h r0=%0d",
                                       c, pc_o, d_info_o, r0_o, epc, exp_info(op), c + 8);
                end
                $display("[TB] stream issue pc=%h info=%h", pc_o, d_info_o);
            end
            if (c < 6) push_in({3'(c), 3'b001}, W_RD'(c + 10), 5'd0, 32'h100 + 32'(4 * c));
            else v_i = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int idx = 0;
        logic [ADDR-1:0] pcs[$];
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (stall_o !== (acc >= DEPTH + 1)) begin
                n_fail++; $display("FAIL bp_stall c=%0d: got %b expected %b", c, stall_o, (acc >= DEPTH + 1));
            end
            if (c >= 2) begin
                n_tests++;
                if (v_o !== 1'b1 || pc_o !== pcs[0]) begin
                    n_fail++; $display("FAIL bp_hold c=%0d: got v=%b pc=%h expected v=1 pc=%h", c, v_o, pc_o, pcs[0]);
                end
            end
            stall_i = 1'b1;
            push_in(6'h00, 5'd1, 5'd2, 32'h200 + 32'(4 * c));
            if (!stall_o) begin acc++; pcs.push_back(pc_i); end
        end
        n_tests++;
        if (acc != DEPTH + 1) begin n_fail++; $display("FAIL bp_accepts: got %0d expected %0d", acc, DEPTH + 1); end
        v_i = 1'b0; stall_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (v_o === 1'b1) begin
                n_tests++;
                if (idx >= pcs.size() || pc_o !== pcs[idx]) begin
                    n_fail++; $display("FAIL bp_order idx=%0d: got pc=%h expected pc=%h", idx, pc_o,
                                       (idx < pcs.size()) ? pcs[idx] : 32'hx);
                end
                $display("[TB] backpressure issue pc=%h", pc_o);
                idx++;
            end
            @(negedge clk);
        end
        n_tests++;
        if (idx != DEPTH + 1) begin n_fail++; $display("FAIL bp_drained: got %0d issues expected %0d", idx, DEPTH + 1); end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        @(negedge clk); push_in(6'b000001, 5'd3, 5'd0, 32'h300);
        @(negedge clk); push_in(6'b000100, 5'd7, 5'd3, 32'h304);
        @(negedge clk); v_i = 1'b0;
        n_tests++;
        if (v_o !== 1'b1 || pc_o !== 32'h300) begin
            n_fail++; $display("FAIL raw_writer: got v=%b pc=%h expected v=1 pc=00000300", v_o, pc_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (v_o !== 1'b0 || busy_o !== 1'b1) begin
                n_fail++; $display("FAIL raw_held k=%0d: got v=%b busy=%b expected v=0 busy=1", k, v_o, busy_o);
            end
        end
        wb_v_i = 1'b1; wb_r_i = 5'd3;
        @(negedge clk); wb_v_i = 1'b0;
        n_tests++;
        if (v_o !== 1'b0) begin n_fail++; $display("FAIL raw_release_lat: got v=%b expected 0", v_o); end
        @(negedge clk);
        n_tests++;
        if (v_o !== 1'b1 || pc_o !== 32'h304 || r1_o !== 5'd3 || d_info_o !== exp_info(6'b000100)) begin
            n_fail++; $display("FAIL raw_reader: got v=%b pc=%h r1=%0d info=%h expected v=1 pc=00000304 r1=3 info=%h",
                               v_o, pc_o, r1_o, d_info_o, exp_info(6'b000100));
        end
        $display("[TB] raw reader issue pc=%h", pc_o);
    endtask

    task automatic test_set_clear();
        do_reset();
        @(negedge clk); push_in(6'b000001, 5'd5, 5'd0, 32'h400);
        @(negedge clk); push_in(6'b000010, 5'd5, 5'd9, 32'h404);
        @(negedge clk); v_i = 1'b0;
        n_tests++;
        if (v_o !== 1'b1 || pc_o !== 32'h400) begin
            n_fail++; $display("FAIL sc_writer: got v=%b pc=%h expected v=1 pc=00000400", v_o, pc_o);
        end
        wb_v_i = 1'b1; wb_r_i = 5'd5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); wb_v_i = 1'b0;
            n_tests++;
            if (v_o !== 1'b0) begin n_fail++; $display("FAIL sc_held k=%0d: got v=%b expected 0", k, v_o); end
        end
        wb_v_i = 1'b1; wb_r_i = 5'd5;
        @(negedge clk); wb_v_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (v_o !== 1'b1 || pc_o !== 32'h404) begin
            n_fail++; $display("FAIL sc_reader: got v=%b pc=%h expected v=1 pc=00000404", v_o, pc_o);
        end
        $display("[TB] set/clear reader issue pc=%h", pc_o);
    endtask

    task automatic test_flush();
        do_reset();
        stall_i = 1'b1;
        for (int c = 0; c < 4; c++) begin @(negedge clk); push_in(6'h00, 5'd1, 5'd1, 32'h500 + 32'(4 * c)); end
        @(negedge clk);
        n_tests++;
        if (v_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre: got v=%b busy=%b expected 1 1", v_o, busy_o);
        end
        flush_i = 1'b1; push_in(6'h00, 5'd1, 5'd1, 32'h5fc);
        @(negedge clk); set_idle();
        n_tests++;
        if ({v_o, busy_o, stall_o} !== 3'b000) begin
            n_fail++; $display("FAIL flush_post: got v/busy/stall=%b expected 000", {v_o, busy_o, stall_o});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (v_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL flush_dropped k=%0d: got v=%b busy=%b expected 0 0", k, v_o, busy_o);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        stall_i = 1'b1;
        for (int c = 0; c < 7; c++) begin @(negedge clk); push_in(6'h01, 5'd2, 5'd0, 32'h600 + 32'(4 * c)); end
        @(negedge clk); v_i = 1'b0;
        n_tests++;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL ar_full: got stall=%b expected 1", stall_o); end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({v_o, stall_o, busy_o} !== 3'b000 || {pc_o, brid_o, imm_o, d_info_o, r0_o, r1_o} !== '0) begin
            n_fail++; $display("FAIL ar_immediate: got v/stall/busy=%b pc=%h info=%h expected all zero",
                               {v_o, stall_o, busy_o}, pc_o, d_info_o);
        end
        @(negedge clk); reset = 1'b1; stall_i = 1'b0;
        push_in(6'h00, 5'd4, 5'd4, 32'h700);
        @(negedge clk); v_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (v_o !== 1'b1 || pc_o !== 32'h700) begin
            n_fail++; $display("FAIL ar_recover: got v=%b pc=%h expected v=1 pc=00000700", v_o, pc_o);
        end
    endtask

    // One randomized cycle: check against the model, drive inputs, then
    // advance the model by what the coming edge does.
    task automatic rand_cycle(input bit allow_new);
        int cand[$];
        logic [5:0] op;
        ent_t e;
        bit fl, st, vv, iss;
        @(negedge clk);
        n_tests++;
        if (busy_o !== (exp_q.size() != 0)) begin
            n_fail++; $display("FAIL rand_busy: got %b expected %b (outstanding %0d)", busy_o, exp_q.size() != 0, exp_q.size());
        end
        fl = allow_new && ($urandom_range(0, 49) == 0);
        st = allow_new && ($urandom_range(0, 3) == 0);
        vv = allow_new && ($urandom_range(0, 9) < 7);
        flush_i = fl; stall_i = st; v_i = vv;
        inst_i = mk_inst(6'($urandom_range(0, 63)), W_RD'($urandom_range(0, 7)), W_RD'($urandom_range(0, 7)),
                         W_IMM'($urandom));
        pc_i = pc_ctr; brid_i = W_BRID'($urandom);
        wb_v_i = 1'b0;
        for (int r = 0; r < 32; r++) if (rsv[r]) cand.push_back(r);
        if (cand.size() != 0 && $urandom_range(0, 2) == 0) begin
            wb_v_i = 1'b1; wb_r_i = W_RD'(cand[$urandom_range(0, cand.size() - 1)]);
        end else if ($urandom_range(0, 7) == 0) begin
            wb_v_i = 1'b1; wb_r_i = W_RD'($urandom_range(16, 31));
        end
        iss = !fl && v_o === 1'b1 && !st;
        if (iss) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL rand_issue: got unexpected issue pc=%h expected no valid output", pc_o);
            end else begin
                e = exp_q.pop_front();
                op = e.inst[31:26];
                if ({pc_o, brid_o, imm_o, r0_o, r1_o, d_info_o} !==
                    {e.pc, e.brid, e.inst[15:0], e.inst[25:21], e.inst[20:16], exp_info(op)}) begin
                    n_fail++; $display("FAIL rand_issue: got pc=%h brid=%0d imm=%h r0=%0d r1=%0d info=%h expected pc=%h brid=%0d imm=%h r0=%0d r1=%0d info=%h",
                                       pc_o, brid_o, imm_o, r0_o, r1_o, d_info_o, e.pc, e.brid, e.inst[15:0],
                                       e.inst[25:21], e.inst[20:16], exp_info(op));
                end
                n_tests++;
                if ((op[1] && rsv[e.inst[25:21]]) || (op[2] && rsv[e.inst[20:16]])) begin
                    n_fail++; $display("FAIL rand_raw: got issue of pc=%h with reserved source expected it held", e.pc);
                end
                $display("[TB] rand issue pc=%h info=%h", pc_o, d_info_o);
                if (wb_v_i) rsv[wb_r_i] = 1'b0;
                if (op[0]) rsv[e.inst[25:21]] = 1'b1;
            end
        end else if (wb_v_i) begin
            rsv[wb_r_i] = 1'b0;
        end
        if (fl) exp_q.delete();
        else if (vv && stall_o === 1'b0) begin
            e.pc = pc_i; e.brid = brid_i; e.inst = inst_i;
            exp_q.push_back(e);
            pc_ctr += 32'd4;
        end
    endtask

    task automatic test_random();
        do_reset();
        exp_q.delete();
        foreach (rsv[r]) rsv[r] = 1'b0;
        pc_ctr = 32'h1000;
        for (int c = 0; c < 700; c++) rand_cycle(1'b1);
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) rand_cycle(1'b0);
        @(negedge clk); set_idle();
        n_tests++;
        if (exp_q.size() != 0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL rand_drain: got %0d outstanding busy=%b expected 0 0", exp_q.size(), busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_raw_hazard();
        test_set_clear();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
